// File: rtl/exec_hazard_ctrl_if.sv
// Execute-stage hazard control bundle: decode/execute status in,
// PC / IF-ID / ID-EX control and perf counters out.
//   master : decode/execute side, drives status, samples controls
//   slave  : exec_hazard_ctrl, samples status, drives controls
interface exec_hazard_ctrl_if #(
   parameter int PC_W = 8
);
   logic            id_valid;
   logic [3:0]      id_instr;
   logic [3:0]      id_rs1;
   logic [3:0]      id_rs2;
   logic            ex_valid;
   logic [3:0]      ex_instr;
   logic [3:0]      ex_regdest;
   logic            jump_selector;
   logic [PC_W-1:0] jump_address;
   logic            mem_busy;
   logic            pc_we;
   logic            pc_sel;
   logic [PC_W-1:0] pc_next;
   logic            ifid_we;
   logic            ifid_flush;
   logic            idex_we;
   logic            idex_bubble;
   logic [15:0]     stall_count;
   logic [15:0]     flush_count;

   modport master (
      output id_valid, id_instr, id_rs1, id_rs2,
      output ex_valid, ex_instr, ex_regdest,
      output jump_selector, jump_address, mem_busy,
      input  pc_we, pc_sel, pc_next,
      input  ifid_we, ifid_flush, idex_we, idex_bubble,
      input  stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_instr, id_rs1, id_rs2,
      input  ex_valid, ex_instr, ex_regdest,
      input  jump_selector, jump_address, mem_busy,
      output pc_we, pc_sel, pc_next,
      output ifid_we, ifid_flush, idex_we, idex_bubble,
      output stall_count, flush_count
   );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage pipeline sequencer: load-use stalls, branch flush,
// memory-busy freeze. Ports: clkwire, rst (async, active-high), bus
// (exec_hazard_ctrl_if.slave). All outputs registered.
// Optional: HAZ_PERF_CNT_EN enables stall_count/flush_count.
module exec_hazard_ctrl #(
   parameter int FLUSH_CYCLES   = 2,
   parameter int LDSTALL_CYCLES = 1,
   parameter int PC_W           = 8
) (
   input  logic              clkwire,
   input  logic              rst,
   exec_hazard_ctrl_if.slave bus
);
   localparam logic [3:0] OP_LW = 4'b0011;
   localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] LS_INIT = 3'(LDSTALL_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN,
      LDSTALL,
      FLUSH,
      FREEZE
   } state_t;

   state_t          state;
   logic [2:0]      cnt;
   logic            pc_we_q;
   logic            pc_sel_q;
   logic [PC_W-1:0] pc_next_q;
   logic            ifid_we_q;
   logic            ifid_flush_q;
   logic            idex_we_q;
   logic            idex_bubble_q;
   logic            uses_rs2;
   logic            hazard;

   // lw has no rs2 operand, so its rs2 field must not trigger a stall
   always_comb begin
      uses_rs2 = (bus.id_instr != OP_LW);
      hazard   = bus.ex_valid & bus.id_valid
               & (bus.ex_instr == OP_LW)
               & ((bus.id_rs1 == bus.ex_regdest)
               | (uses_rs2
               & (bus.id_rs2 == bus.ex_regdest)));
   end

   always_ff @(posedge clkwire or posedge rst) begin
      if (rst) begin
         state         <= RUN;
         cnt           <= '0;
         pc_we_q       <= 1'b1;
         pc_sel_q      <= 1'b0;
         pc_next_q     <= '0;
         ifid_we_q     <= 1'b1;
         ifid_flush_q  <= 1'b0;
         idex_we_q     <= 1'b1;
         idex_bubble_q <= 1'b0;
      end else begin
         state         <= RUN;
         cnt           <= '0;
         pc_we_q       <= 1'b1;
         pc_sel_q      <= 1'b0;
         ifid_we_q     <= 1'b1;
         ifid_flush_q  <= 1'b0;
         idex_we_q     <= 1'b1;
         idex_bubble_q <= 1'b0;
         if (bus.jump_selector) begin
            state         <= FLUSH;
            cnt           <= FL_INIT;
            pc_sel_q      <= 1'b1;
            pc_next_q     <= bus.jump_address;
            ifid_flush_q  <= 1'b1;
            idex_bubble_q <= 1'b1;
         end else begin
            unique case (state)
               RUN: begin
                  if (bus.mem_busy) begin
                     state     <= FREEZE;
                     pc_we_q   <= 1'b0;
                     ifid_we_q <= 1'b0;
                     idex_we_q <= 1'b0;
                  end else if (hazard) begin
                     state         <= LDSTALL;
                     cnt           <= LS_INIT;
                     pc_we_q       <= 1'b0;
                     ifid_we_q     <= 1'b0;
                     idex_bubble_q <= 1'b1;
                  end
               end
               LDSTALL: begin
                  // a freeze drops the stall; decode is re-checked after
                  if (bus.mem_busy) begin
                     state     <= FREEZE;
                     pc_we_q   <= 1'b0;
                     ifid_we_q <= 1'b0;
                     idex_we_q <= 1'b0;
                  end else if (cnt != 3'd0) begin
                     state         <= LDSTALL;
                     cnt           <= cnt - 3'd1;
                     pc_we_q       <= 1'b0;
                     ifid_we_q     <= 1'b0;
                     idex_bubble_q <= 1'b1;
                  end
               end
               FLUSH: begin
                  // busy memory parks the flush with its count intact
                  if (bus.mem_busy) begin
                     state         <= FLUSH;
                     cnt           <= cnt;
                     pc_we_q       <= 1'b0;
                     ifid_we_q     <= 1'b0;
                     idex_we_q     <= 1'b0;
                     ifid_flush_q  <= 1'b1;
                     idex_bubble_q <= 1'b1;
                  end else if (cnt != 3'd0) begin
                     state         <= FLUSH;
                     cnt           <= cnt - 3'd1;
                     ifid_flush_q  <= 1'b1;
                     idex_bubble_q <= 1'b1;
                  end
               end
               FREEZE: begin
                  if (bus.mem_busy) begin
                     state     <= FREEZE;
                     pc_we_q   <= 1'b0;
                     ifid_we_q <= 1'b0;
                     idex_we_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.pc_we       = pc_we_q;
   assign bus.pc_sel      = pc_sel_q;
   assign bus.pc_next     = pc_next_q;
   assign bus.ifid_we     = ifid_we_q;
   assign bus.ifid_flush  = ifid_flush_q;
   assign bus.idex_we     = idex_we_q;
   assign bus.idex_bubble = idex_bubble_q;

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // a jump taken out of FREEZE is not counted as a redirect entry
   always_ff @(posedge clkwire or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (state == LDSTALL && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (bus.jump_selector && state != FREEZE
             && flush_cnt_q != 16'hFFFF)
            flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
`else
   assign bus.stall_count = 16'h0000;
   assign bus.flush_count = 16'h0000;
`endif
endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Scoreboard bench for exec_hazard_ctrl: directed scenarios then
// randomized traffic against a cycle-level reference model.
module tb_exec_hazard_ctrl;
   localparam int FLC = 2;
   localparam int LSC = 1;
`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic        pc_we;
      logic        pc_sel;
      logic [7:0]  pc_next;
      logic        ifid_we;
      logic        ifid_flush;
      logic        idex_we;
      logic        idex_bubble;
      logic [15:0] sc;
      logic [15:0] fc;
   } out_t;

   logic clkwire = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   out_t expq[$];

   exec_hazard_ctrl_if #(.PC_W(8)) bus();

   exec_hazard_ctrl #(
      .FLUSH_CYCLES(FLC),
      .LDSTALL_CYCLES(LSC),
      .PC_W(8)
   ) dut (
      .clkwire(clkwire),
      .rst(rst),
      .bus(bus)
   );

   always #5 clkwire = ~clkwire;

   // reference model: phase name plus cycles still owed in that phase
   int   m_phase;
   int   m_owed;
   out_t m_out;
   int   m_stalls;
   int   m_flushes;

   function automatic out_t reset_vals();
      out_t o;
      o = '0;
      o.pc_we = 1'b1;
      o.ifid_we = 1'b1;
      o.idex_we = 1'b1;
      return o;
   endfunction

   function automatic out_t cur();
      out_t o;
      o = m_out;
      o.sc = PERF ? 16'(m_stalls) : 16'h0;
      o.fc = PERF ? 16'(m_flushes) : 16'h0;
      return o;
   endfunction

   function automatic out_t got();
      out_t o;
      o.pc_we = bus.pc_we;
      o.pc_sel = bus.pc_sel;
      o.pc_next = bus.pc_next;
      o.ifid_we = bus.ifid_we;
      o.ifid_flush = bus.ifid_flush;
      o.idex_we = bus.idex_we;
      o.idex_bubble = bus.idex_bubble;
      o.sc = bus.stall_count;
      o.fc = bus.flush_count;
      return o;
   endfunction

   // phases: 0 run, 1 load stall, 2 flush, 3 freeze
   task automatic model_reset();
      m_phase = 0;
      m_owed = 0;
      m_out = reset_vals();
      m_stalls = 0;
      m_flushes = 0;
   endtask

   task automatic model_edge(input bit jmp, input logic [7:0] ja,
                             input bit mb, input bit haz);
      logic [7:0] keep_pc;
      keep_pc = m_out.pc_next;
      if (m_phase == 1 && m_stalls < 65535) m_stalls++;
      m_out = reset_vals();
      m_out.pc_next = keep_pc;
      if (jmp) begin
         if (m_phase != 3 && m_flushes < 65535) m_flushes++;
         m_phase = 2;
         m_owed = FLC - 1;
         m_out.pc_sel = 1'b1;
         m_out.pc_next = ja;
         m_out.ifid_flush = 1'b1;
         m_out.idex_bubble = 1'b1;
      end else if (mb) begin
         m_out.pc_we = 1'b0;
         m_out.ifid_we = 1'b0;
         m_out.idex_we = 1'b0;
         if (m_phase == 2) begin
            m_out.ifid_flush = 1'b1;
            m_out.idex_bubble = 1'b1;
         end else begin
            m_phase = 3;
         end
      end else if (m_phase == 0 && haz) begin
         m_phase = 1;
         m_owed = LSC - 1;
         m_out.pc_we = 1'b0;
         m_out.ifid_we = 1'b0;
         m_out.idex_bubble = 1'b1;
      end else if (m_phase inside {1, 2} && m_owed > 0) begin
         m_owed--;
         if (m_phase == 1) begin
            m_out.pc_we = 1'b0;
            m_out.ifid_we = 1'b0;
         end else begin
            m_out.ifid_flush = 1'b1;
         end
         m_out.idex_bubble = 1'b1;
      end else begin
         m_phase = 0;
         m_owed = 0;
      end
   endtask

   task automatic compare(input string nm, input out_t g,
                          input out_t e);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL %s got=%h required=%h", nm, g, e);
      end
   endtask

   // one cycle of stimulus, driven at negedge; expectation queued
   task automatic step(input bit r, input bit jv,
                       input logic [7:0] ja, input bit mb,
                       input bit iv, input logic [3:0] ii,
                       input logic [3:0] r1, input logic [3:0] r2,
                       input bit xv, input logic [3:0] xi,
                       input logic [3:0] xd);
      bit haz;
      @(negedge clkwire);
      bus.jump_selector = jv;
      bus.jump_address = ja;
      bus.mem_busy = mb;
      bus.id_valid = iv;
      bus.id_instr = ii;
      bus.id_rs1 = r1;
      bus.id_rs2 = r2;
      bus.ex_valid = xv;
      bus.ex_instr = xi;
      bus.ex_regdest = xd;
      haz = xv && iv && xi == 4'b0011
         && (r1 == xd || (ii != 4'b0011 && r2 == xd));
      if (r) begin
         rst = 1'b1;
         #1;
         compare("async_rst", got(), reset_vals());
         model_reset();
      end else begin
         rst = 1'b0;
         model_edge(jv, ja, mb, haz);
      end
      expq.push_back(cur());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rnd(input bit allow_rst);
      bit r;
      r = allow_rst && ($urandom_range(0, 199) == 0);
      step(r, $urandom_range(0, 9) == 0, 8'($urandom),
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'($urandom),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'($urandom),
           4'($urandom_range(0, 3)));
   endtask

   initial begin : monitor
      out_t e;
      forever begin
         @(posedge clkwire);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            compare("outs", got(), e);
         end
      end
   end

   initial begin : stim
      bus.jump_selector = 1'b0;
      bus.jump_address = '0;
      bus.mem_busy = 1'b0;
      bus.id_valid = 1'b0;
      bus.id_instr = '0;
      bus.id_rs1 = '0;
      bus.id_rs2 = '0;
      bus.ex_valid = 1'b0;
      bus.ex_instr = '0;
      bus.ex_regdest = '0;
      model_reset();
      for (int i = 0; i < 3; i++) rnd(0);
      for (int i = 0; i < 3; i++)
         step(1, 1, 8'hFF, 1, 1, 4'b0011, 3, 3, 1, 4'b0011, 3);
      idle(3);
      // load-use: lw r3 in ex, add using r3 in id
      step(0, 0, 0, 0, 1, 4'b0000, 3, 7, 1, 4'b0011, 3);
      idle(3);
      // lw in id with rs2 matching is not a hazard
      step(0, 0, 0, 0, 1, 4'b0011, 5, 3, 1, 4'b0011, 3);
      idle(2);
      // taken branch
      step(0, 1, 8'h2A, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      // branch, busy and hazard together
      step(0, 1, 8'h55, 1, 1, 4'b0000, 3, 3, 1, 4'b0011, 3);
      idle(4);
      // busy memory in the middle of a flush
      step(0, 1, 8'h13, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      // reset pulse mid-flush
      step(0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      for (int i = 0; i < 3000; i++) rnd(1);
      idle(2);
      repeat (3) @(posedge clkwire);
      #2;
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d required=0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
